// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum: framed XOR checksum with word count, overflow flag and valid/ready handshakes
module xor_stream_checksum #(
  parameter int WIDTH = 8,
  parameter int MAX_WORDS = 16,
  parameter int CW = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [CW-1:0] MAXC = CW'(MAX_WORDS);
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, sum_nx;
  logic [CW-1:0] cnt;
  logic ovf, acc_en, full;
  always_comb begin
    acc_en = in_valid & in_ready;
    full = cnt == MAXC;
    sum_nx = acc ^ in_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else state <= state_nx;
  always_comb
    state_nx = clear ? ACCUM :
               (state == ACCUM) ? ((acc_en & in_last) ? HOLD : ACCUM) :
               (out_valid & out_ready) ? ACCUM : HOLD;
  always_comb in_ready = state == ACCUM;
  // the count saturates at MAX_WORDS; words past it still fold into the sum
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_sum <= '0;
      out_parity <= 1'b0;
      out_count <= '0;
      out_overflow <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_sum <= '0;
      out_parity <= 1'b0;
      out_count <= '0;
      out_overflow <= 1'b0;
      out_valid <= 1'b0;
    end else if (acc_en & in_last) begin
      out_sum <= sum_nx;
      out_parity <= ^sum_nx;
      out_count <= full ? MAXC : cnt + 1'b1;
      out_overflow <= ovf | full;
      out_valid <= 1'b1;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (acc_en) begin
      acc <= sum_nx;
      cnt <= full ? cnt : cnt + 1'b1;
      ovf <= ovf | full;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_xor_stream_checksum.sv
// tb_xor_stream_checksum: directed and random frames checked against a queue-based reference model
module tb_xor_stream_checksum;
  localparam int W = 8;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_parity, out_overflow, out_valid;
  logic [W-1:0] out_sum;
  logic [CW-1:0] out_count;
  int n_checks = 0, n_err = 0;
  logic [W-1:0] frame[$];
  logic [W-1:0] held;

  xor_stream_checksum #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum), .out_parity(out_parity),
    .out_count(out_count), .out_overflow(out_overflow), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sum"}, 32'(out_sum), 0);
    chk({tag, ".par"}, 32'(out_parity), 0);
    chk({tag, ".cnt"}, 32'(out_count), 0);
    chk({tag, ".ovf"}, 32'(out_overflow), 0);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".ready"}, 32'(in_ready), 1);
  endtask

  // present one word for one cycle; caller must know the block is in ACCUM
  task automatic put(input logic [W-1:0] d, input logic last);
    chk("put.in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    frame.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_data = W'($urandom);
      in_last = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_last = 1'b0;
  endtask

  // expected result from the frame contents alone
  task automatic chk_result(input string tag);
    logic [W-1:0] s;
    int n;
    s = '0;
    foreach (frame[i]) s ^= frame[i];
    n = frame.size();
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".sum"}, 32'(out_sum), 32'(s));
    chk({tag, ".par"}, 32'(out_parity), 32'(^s));
    chk({tag, ".cnt"}, 32'(out_count), (n > MW) ? MW : n);
    chk({tag, ".ovf"}, 32'(out_overflow), 32'(n > MW));
    chk({tag, ".ready"}, 32'(in_ready), 0);
    frame.delete();
  endtask

  task automatic drain(input string tag);
    held = out_sum;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 0);
    chk({tag, ".ready_back"}, 32'(in_ready), 1);
    chk({tag, ".sum_kept"}, 32'(out_sum), 32'(held));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.sum", 32'(out_sum), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.cnt", 32'(out_count), 0);
    chk("rst.ovf", 32'(out_overflow), 0);
    rst = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 1);

    put(8'h0F, 1'b0);
    put(8'hF0, 1'b0);
    put(8'hAA, 1'b1);
    chk("f1.sum_const", 32'(out_sum), 32'h55);
    chk_result("f1");

    held = out_sum;
    in_valid = 1'b1;
    in_data = 8'h77;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp.in_ready", 32'(in_ready), 0);
      chk("bp.valid", 32'(out_valid), 1);
      chk("bp.sum", 32'(out_sum), 32'(held));
      chk("bp.cnt", 32'(out_count), 3);
    end
    in_valid = 1'b0;
    drain("bp");

    idle(2);
    put(8'h01, 1'b1);
    chk("single.sum_const", 32'(out_sum), 32'h01);
    chk_result("single");
    drain("single");

    put(8'h01, 1'b0);
    put(8'h02, 1'b0);
    put(8'h04, 1'b0);
    put(8'h08, 1'b0);
    put(8'h10, 1'b1);
    chk("ovf.sum_const", 32'(out_sum), 32'h1F);
    chk("ovf.flag_const", 32'(out_overflow), 1);
    chk_result("ovf");
    drain("ovf");
    put(8'hFF, 1'b1);
    chk_result("post_ovf");
    drain("post_ovf");

    put(8'hAA, 1'b0);
    put(8'h55, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    frame.delete();
    chk_zero("clr");
    put(8'h3C, 1'b1);
    chk("clr.sum_const", 32'(out_sum), 32'h3C);
    chk_result("clr");
    drain("clr");

    put(8'hAA, 1'b0);
    put(8'h55, 1'b0);
    #2 rst = 1'b1;
    #2 chk_zero("arst");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    frame.delete();
    put(8'h3C, 1'b1);
    chk_result("arst");
    drain("arst");

    // clear while a result is pending drops it
    put(8'h5A, 1'b1);
    chk_result("hold_clr.pre");
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk_zero("hold_clr");

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        put(W'($urandom), 1'(i == len - 1));
      end
      held = out_sum;
      chk_result("rnd");
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom);
        in_data = W'($urandom);
        @(posedge clk);
        #1;
        chk("rnd.hold_valid", 32'(out_valid), 1);
        chk("rnd.hold_sum", 32'(out_sum), 32'(held));
      end
      in_valid = 1'b0;
      drain("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/xor_stream_checksum.md
Name: xor_stream_checksum

Overview:
- Parametrised, sequential successor to the two-input XOR gate.
- Accumulates a bitwise XOR checksum over a framed stream of WIDTH-bit words.
- Reports the checksum, its reduction parity, the word count and an overflow flag once per frame.
- Used as a lightweight integrity check on internal datapaths. Handshaked valid/ready on both input and output sides.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- MAX_WORDS, 16: maximum words per frame before overflow is flagged (>=1).
- CW, $clog2(MAX_WORDS+1): counter width. Derived; not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear; aborts the current frame.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final word of a frame; qualified by in_valid.
- in_ready  output  1  block can accept a word.
- out_sum  output  WIDTH  XOR of all accepted words in the frame.
- out_parity  output  1  reduction XOR of out_sum.
- out_count  output  CW  accepted words in the frame, saturating at MAX_WORDS.
- out_overflow  output  1  frame contained more than MAX_WORDS words.
- out_valid  output  1  result outputs valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- States are ACCUM and HOLD. Reset state is ACCUM.
- rst asserted (asynchronous):
  - state=ACCUM.
  - Accumulator, counter and overflow register = 0.
  - out_sum=0, out_parity=0, out_count=0, out_overflow=0, out_valid=0.
- in_ready = (state==ACCUM), combinational from state only. It is 1 in the first cycle after reset deasserts.
- Word accept = in_valid & in_ready.
- ACCUM, accept with in_last=0:
  - acc <= acc ^ in_data.
  - If cnt==MAX_WORDS: ovf <= 1. Otherwise cnt <= cnt+1.
- ACCUM, accept with in_last=1:
  - out_sum <= acc ^ in_data.
  - out_parity <= ^(acc ^ in_data).
  - out_count <= saturated cnt+1.
  - out_overflow <= ovf | (cnt==MAX_WORDS).
  - out_valid <= 1. acc, cnt, ovf <= 0. state <= HOLD.
- Latency: out_valid rises the cycle after the last word is accepted.
- HOLD:
  - in_ready=0. All out_* are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_valid <= 0 and state <= ACCUM. out_sum, out_count and the other result outputs keep their last values.
  - A new frame can be accepted from the next cycle.
- in_valid=0 in ACCUM: no state change. Idle gaps inside a frame are legal.
- in_last without in_valid is ignored.
- Overflow: words beyond MAX_WORDS are still XORed into the sum. The count stays at MAX_WORDS and the overflow flag is set.
- clear=1 (synchronous, highest priority after rst):
  - Effect matches rst, but at the clock edge.
  - Any word presented that cycle is discarded.
  - In HOLD, a pending result is dropped (out_valid <= 0).
- rst mid-frame or mid-HOLD: partial frame and pending result are lost. No output pulse is generated.
- No combinational path from in_* to out_*. All outputs except in_ready are registered.

Test Plan:
- Reset: assert rst 3 cycles -> all out_* = 0, out_valid=0. in_ready=1 on the first cycle after deassert.
- Frame (WIDTH=8, MAX_WORDS=4), words 0x0F, 0xF0, 0xAA(last), back-to-back -> cycle after 0xAA accept: out_valid=1, out_sum=0x55, out_parity=0, out_count=3, out_overflow=0.
- Backpressure: after the above, out_ready=0 for 5 cycles while in_valid=1, in_data=0x77 -> in_ready=0, outputs stable, 0x77 not absorbed. Then out_ready=1 -> out_valid=0 next cycle and in_ready=1.
- Single word with gaps: idle 2 cycles, then 0x01 with last -> out_sum=0x01, out_parity=1, out_count=1.
- Overflow: words 0x01, 0x02, 0x04, 0x08, 0x10(last), MAX_WORDS=4 -> out_sum=0x1F, out_parity=1, out_count=4, out_overflow=1. The next frame 0xFF(last) gives out_overflow=0, out_count=1.
- Abort: words 0xAA, 0x55, then clear=1 for one cycle with in_valid=1, in_data=0x99 -> 0x99 dropped. Then 0x3C(last) -> out_sum=0x3C, out_count=1. Repeat the sequence using async rst mid-frame; expect the same result.
